// File: rtl/conv_icb_loader.sv
// ICB master that loads image/filter words from a stream into the convolution
// accelerator, writes its start bit and polls the status register until done.
module conv_icb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
    parameter logic [31:0] CTRL_OFS  = 32'h0000_0040,
    parameter logic [31:0] IMG_OFS   = 32'h0000_0100,
    parameter logic [31:0] FLT_OFS   = 32'h0000_0200,
    parameter int          CNT_W     = 8,
    parameter int          MAX_POLL  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_start,
    input  logic [CNT_W-1:0] num_img,
    input  logic [CNT_W-1:0] num_flt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_addr,
    output logic [31:0]      icb_cmd_wdata,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int                POLL_W     = $clog2(MAX_POLL + 1);
    localparam logic [31:0]       CTRL_ADDR  = BASE_ADDR + CTRL_OFS;
    localparam logic [31:0]       IMG_BASE   = BASE_ADDR + IMG_OFS;
    localparam logic [31:0]       FLT_BASE   = BASE_ADDR + FLT_OFS;
    localparam logic [CNT_W:0]    CNT_ONE    = (CNT_W+1)'(32'd1);
    localparam logic [POLL_W-1:0] POLL_ONE   = POLL_W'(32'd1);
    localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(MAX_POLL);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_IMG_CMD  = 4'd1,
        S_IMG_RSP  = 4'd2,
        S_FLT_CMD  = 4'd3,
        S_FLT_RSP  = 4'd4,
        S_GO_CMD   = 4'd5,
        S_GO_RSP   = 4'd6,
        S_POLL_CMD = 4'd7,
        S_POLL_RSP = 4'd8,
        S_DONE     = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  num_img_r;
    logic [CNT_W-1:0]  num_flt_r;
    logic [CNT_W-1:0]  img_idx_r;
    logic [CNT_W-1:0]  flt_idx_r;
    logic [POLL_W-1:0] poll_cnt_r;

    logic [CNT_W:0]    img_next_s;
    logic [CNT_W:0]    flt_next_s;
    logic              img_last_s;
    logic              flt_last_s;
    logic [POLL_W-1:0] poll_next_s;
    logic [31:0]       img_addr_s;
    logic [31:0]       flt_addr_s;
    logic              wr_hs_s;
    logic              unused_rdata_s;

    // Word indices compared one ahead so the last response decides the exit.
    assign img_next_s  = {1'b0, img_idx_r} + CNT_ONE;
    assign flt_next_s  = {1'b0, flt_idx_r} + CNT_ONE;
    assign img_last_s  = (img_next_s == {1'b0, num_img_r});
    assign flt_last_s  = (flt_next_s == {1'b0, num_flt_r});
    assign poll_next_s = poll_cnt_r + POLL_ONE;
    assign img_addr_s  = IMG_BASE + 32'({img_idx_r, 2'b00});
    assign flt_addr_s  = FLT_BASE + 32'({flt_idx_r, 2'b00});
    assign wr_hs_s     = in_valid && icb_cmd_ready;

    // Only the done bit of the status register matters.
    assign unused_rdata_s = ^{icb_rsp_rdata[31:2], icb_rsp_rdata[0]};

    // Job sequencing: state, captured counts, word indices and poll counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            num_img_r  <= {CNT_W{1'b0}};
            num_flt_r  <= {CNT_W{1'b0}};
            img_idx_r  <= {CNT_W{1'b0}};
            flt_idx_r  <= {CNT_W{1'b0}};
            poll_cnt_r <= {POLL_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (job_start) begin
                        num_img_r  <= num_img;
                        num_flt_r  <= num_flt;
                        img_idx_r  <= {CNT_W{1'b0}};
                        flt_idx_r  <= {CNT_W{1'b0}};
                        poll_cnt_r <= {POLL_W{1'b0}};
                        if (num_img != {CNT_W{1'b0}}) begin
                            state_r <= S_IMG_CMD;
                        end else if (num_flt != {CNT_W{1'b0}}) begin
                            state_r <= S_FLT_CMD;
                        end else begin
                            state_r <= S_GO_CMD;
                        end
                    end
                end
                S_IMG_CMD: begin
                    if (wr_hs_s) begin
                        state_r <= S_IMG_RSP;
                    end
                end
                S_IMG_RSP: begin
                    if (icb_rsp_valid) begin
                        if (icb_rsp_err) begin
                            state_r <= S_ERR;
                        end else begin
                            img_idx_r <= img_next_s[CNT_W-1:0];
                            if (!img_last_s) begin
                                state_r <= S_IMG_CMD;
                            end else if (num_flt_r != {CNT_W{1'b0}}) begin
                                state_r <= S_FLT_CMD;
                            end else begin
                                state_r <= S_GO_CMD;
                            end
                        end
                    end
                end
                S_FLT_CMD: begin
                    if (wr_hs_s) begin
                        state_r <= S_FLT_RSP;
                    end
                end
                S_FLT_RSP: begin
                    if (icb_rsp_valid) begin
                        if (icb_rsp_err) begin
                            state_r <= S_ERR;
                        end else begin
                            flt_idx_r <= flt_next_s[CNT_W-1:0];
                            state_r   <= flt_last_s ? S_GO_CMD : S_FLT_CMD;
                        end
                    end
                end
                S_GO_CMD: begin
                    if (icb_cmd_ready) begin
                        state_r <= S_GO_RSP;
                    end
                end
                S_GO_RSP: begin
                    if (icb_rsp_valid) begin
                        state_r <= icb_rsp_err ? S_ERR : S_POLL_CMD;
                    end
                end
                S_POLL_CMD: begin
                    if (icb_cmd_ready) begin
                        state_r <= S_POLL_RSP;
                    end
                end
                S_POLL_RSP: begin
                    if (icb_rsp_valid) begin
                        if (icb_rsp_err) begin
                            state_r <= S_ERR;
                        end else if (icb_rsp_rdata[1]) begin
                            state_r <= S_DONE;
                        end else begin
                            poll_cnt_r <= poll_next_s;
                            state_r    <= (poll_next_s == POLL_LIMIT) ? S_ERR : S_POLL_CMD;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // ICB/stream outputs decoded from the state register; write commands pass
    // the stream straight through so both handshakes land in the same cycle.
    always_comb begin
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h0000_0000;
        icb_cmd_wdata = 32'h0000_0000;
        icb_rsp_ready = 1'b0;
        in_ready      = 1'b0;
        case (state_r)
            S_IMG_CMD: begin
                icb_cmd_valid = in_valid;
                icb_cmd_addr  = img_addr_s;
                icb_cmd_wdata = in_data;
                in_ready      = icb_cmd_ready;
            end
            S_FLT_CMD: begin
                icb_cmd_valid = in_valid;
                icb_cmd_addr  = flt_addr_s;
                icb_cmd_wdata = in_data;
                in_ready      = icb_cmd_ready;
            end
            S_GO_CMD: begin
                icb_cmd_valid = 1'b1;
                icb_cmd_addr  = CTRL_ADDR;
                icb_cmd_wdata = 32'h0000_0001;
            end
            S_POLL_CMD: begin
                icb_cmd_valid = 1'b1;
                icb_cmd_read  = 1'b1;
                icb_cmd_addr  = CTRL_ADDR;
            end
            S_IMG_RSP, S_FLT_RSP, S_GO_RSP, S_POLL_RSP: begin
                icb_rsp_ready = 1'b1;
            end
            default: begin
                icb_cmd_valid = 1'b0;
            end
        endcase
    end

    // Job status flags.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule
